// File: rtl/mw_pkg.sv
// Shared types and constants for the stage-3 memory/writeback slice.
package mw_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_RESP = 2'd2
  } mw_state_e;

  localparam logic [1:0] WB_MEM  = 2'b00;
  localparam logic [1:0] WB_ALU  = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;
  localparam logic [1:0] WB_ZERO = 2'b11;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // funct3[1:0] gives the access size for both loads and stores
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

endpackage

// File: rtl/mw_load_align.sv
// Extracts and extends load data from a returned cache word.
module mw_load_align
  import mw_pkg::*;
(
  input  logic [31:0] dcache_dout,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  output logic [31:0] load_value
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the addressed byte/half, then extend according to funct3
  always_comb begin
    byte_sel   = dcache_dout[{offset, 3'b000} +: 8];
    half_sel   = offset[1] ? dcache_dout[31:16] : dcache_dout[15:0];
    load_value = dcache_dout;
    case (funct3)
      F3_LB:   load_value = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   load_value = {{16{half_sel[15]}}, half_sel};
      F3_LW:   load_value = dcache_dout;
      F3_LBU:  load_value = {24'd0, byte_sel};
      F3_LHU:  load_value = {16'd0, half_sel};
      default: load_value = dcache_dout;
    endcase
  end

endmodule

// File: rtl/mw_mem_access.sv
// Stage-3 memory access and writeback register.
// Optional feature macro: MW_MISALIGN_TRAP_EN (misaligned accesses trap
// and raise misalign_err instead of having their low address bits masked).
module mw_mem_access
  import mw_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  input  logic [2:0]      funct3,
  input  logic [3:0]      w_mask,
  input  logic            re,
  input  logic [1:0]      wb_sel,
  input  logic            rwe,
  input  logic [4:0]      rd,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] pc_plus4,
  output logic            dcache_req_valid,
  input  logic            dcache_req_ready,
  output logic [XLEN-1:0] dcache_addr,
  output logic            dcache_re,
  output logic [3:0]      dcache_we,
  output logic [XLEN-1:0] dcache_din,
  input  logic            dcache_resp_valid,
  input  logic [XLEN-1:0] dcache_dout,
  output logic            stall,
`ifdef MW_MISALIGN_TRAP_EN
  output logic            misalign_err,
`endif
  output logic            wb_valid,
  output logic            wb_we,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data
);

  mw_state_e       state, next_state;
  logic            mem_op, misaligned, issue;
  logic            store_done, load_done, pass_done, mis_done, complete;
  logic            size_half, size_word;
  logic [1:0]      eff_off;
  logic [XLEN-1:0] load_value, wb_next;

  assign size_half = (funct3[1:0] == SIZE_HALF);
  assign size_word = (funct3[1:0] == SIZE_WORD);
  assign mem_op    = in_valid & (re | (|w_mask));

`ifdef MW_MISALIGN_TRAP_EN
  // Misaligned half/word accesses are trapped rather than issued
  always_comb begin
    misaligned = (size_half & alu_result[0]) | (size_word & (|alu_result[1:0]));
    eff_off    = alu_result[1:0];
  end
`else
  // Misaligned half/word accesses silently drop the offending offset bits
  always_comb begin
    misaligned = 1'b0;
    if (size_word)      eff_off = 2'b00;
    else if (size_half) eff_off = {alu_result[1], 1'b0};
    else                eff_off = alu_result[1:0];
  end
`endif

  assign issue = mem_op & ~misaligned;

  // Request fields follow the held stage-3 inputs, so they stay stable until accepted
  assign dcache_addr = {alu_result[XLEN-1:2], 2'b00};
  assign dcache_re   = re;
  assign dcache_we   = w_mask << eff_off;
  assign dcache_din  = store_data << {eff_off, 3'b000};

  // State register; reset abandons any access in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Next state and handshake; the request is raised in the same cycle an op arrives
  always_comb begin
    next_state       = state;
    dcache_req_valid = 1'b0;
    store_done       = 1'b0;
    load_done        = 1'b0;
    unique case (state)
      IDLE: begin
        if (issue) begin
          dcache_req_valid = 1'b1;
          if (dcache_req_ready) begin
            if (re) next_state = WAIT_RESP;
            else    store_done = 1'b1;
          end else begin
            next_state = REQ;
          end
        end
      end
      REQ: begin
        dcache_req_valid = 1'b1;
        if (dcache_req_ready) begin
          if (re) begin
            next_state = WAIT_RESP;
          end else begin
            store_done = 1'b1;
            next_state = IDLE;
          end
        end
      end
      WAIT_RESP: begin
        if (dcache_resp_valid) begin
          load_done  = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign pass_done = in_valid & ~mem_op & (state == IDLE);
  assign mis_done  = mem_op & misaligned & (state == IDLE);
  assign complete  = pass_done | store_done | load_done | mis_done;
  assign stall     = ((state != IDLE) | issue) & ~(store_done | load_done);

  mw_load_align u_load_align (
    .dcache_dout (dcache_dout),
    .funct3      (funct3),
    .offset      (eff_off),
    .load_value  (load_value)
  );

  // Writeback source select
  always_comb begin
    wb_next = '0;
    case (wb_sel)
      WB_MEM:  wb_next = load_value;
      WB_ALU:  wb_next = alu_result;
      WB_PC4:  wb_next = pc_plus4;
      default: wb_next = '0;
    endcase
  end

  // Writeback register; wb_valid pulses once per completed instruction
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
    end else begin
      wb_valid <= complete;
      if (complete) begin
        wb_we   <= rwe & (rd != 5'd0) & ~mis_done;
        wb_rd   <= rd;
        wb_data <= wb_next;
      end
    end
  end

`ifdef MW_MISALIGN_TRAP_EN
  // Trap flag aligned with the writeback of the offending instruction
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) misalign_err <= 1'b0;
    else          misalign_err <= mis_done;
  end
`endif

endmodule

// File: tb/tb_mw_mem_access.sv
// Scoreboard bench for mw_mem_access; honours MW_MISALIGN_TRAP_EN when defined.
module tb_mw_mem_access;
  import mw_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, re, rwe;
  logic [2:0]  funct3;
  logic [3:0]  w_mask;
  logic [1:0]  wb_sel;
  logic [4:0]  rd;
  logic [31:0] alu_result, store_data, pc_plus4;
  logic        dcache_req_valid, dcache_req_ready, dcache_re;
  logic [31:0] dcache_addr, dcache_din, dcache_dout;
  logic [3:0]  dcache_we;
  logic        dcache_resp_valid;
  logic        stall;
  logic        wb_valid, wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
`ifdef MW_MISALIGN_TRAP_EN
  logic        misalign_err;
`endif

  typedef struct {
    logic [4:0]  rd;
    logic        we;
    logic [31:0] data;
  } wb_exp_t;

  wb_exp_t exp_q[$];
  wb_exp_t mon_exp;
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mw_mem_access #(.XLEN(32)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .in_valid          (in_valid),
    .funct3            (funct3),
    .w_mask            (w_mask),
    .re                (re),
    .wb_sel            (wb_sel),
    .rwe               (rwe),
    .rd                (rd),
    .alu_result        (alu_result),
    .store_data        (store_data),
    .pc_plus4          (pc_plus4),
    .dcache_req_valid  (dcache_req_valid),
    .dcache_req_ready  (dcache_req_ready),
    .dcache_addr       (dcache_addr),
    .dcache_re         (dcache_re),
    .dcache_we         (dcache_we),
    .dcache_din        (dcache_din),
    .dcache_resp_valid (dcache_resp_valid),
    .dcache_dout       (dcache_dout),
    .stall             (stall),
`ifdef MW_MISALIGN_TRAP_EN
    .misalign_err      (misalign_err),
`endif
    .wb_valid          (wb_valid),
    .wb_we             (wb_we),
    .wb_rd             (wb_rd),
    .wb_data           (wb_data)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    in_valid = 0; re = 0; w_mask = 0; rwe = 0; wb_sel = 0; rd = 0; funct3 = 0;
    alu_result = 0; store_data = 0; pc_plus4 = 0;
    dcache_req_ready = 0; dcache_resp_valid = 0; dcache_dout = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [2:0] f3, input logic [3:0] wm, input logic re_i,
                                input logic [1:0] sel, input logic rwe_i, input logic [4:0] rd_i,
                                input logic [31:0] alu, input logic [31:0] sd, input logic [31:0] pc4);
    in_valid = 1; funct3 = f3; w_mask = wm; re = re_i; wb_sel = sel; rwe = rwe_i; rd = rd_i;
    alu_result = alu; store_data = sd; pc_plus4 = pc4;
  endtask

  // Non-memory instruction: no request, no stall, writeback next edge
  task automatic run_alu(input string tag, input logic [1:0] sel, input logic [4:0] rd_i,
                         input logic [31:0] alu, input logic [31:0] pc4,
                         input logic exp_we, input logic [31:0] exp_data);
    apply_stimulus(F3_LB, 4'b0000, 1'b0, sel, 1'b1, rd_i, alu, 32'd0, pc4);
    exp_q.push_back('{rd: rd_i, we: exp_we, data: exp_data});
    @(negedge clk);
    check_output({tag, "_stall"}, {31'd0, stall}, 32'd0);
    check_output({tag, "_req_valid"}, {31'd0, dcache_req_valid}, 32'd0);
    next_cycle();
    idle_inputs();
  endtask

  task automatic run_store(input string tag, input logic [2:0] f3, input logic [3:0] wm,
                           input logic [31:0] addr, input logic [31:0] sd, input int ready_delay,
                           input logic [31:0] exp_addr, input logic [3:0] exp_we,
                           input logic [31:0] exp_din);
    int stall_cycles = 0;
    apply_stimulus(f3, wm, 1'b0, WB_ALU, 1'b0, 5'd0, addr, sd, 32'd0);
    exp_q.push_back('{rd: 5'd0, we: 1'b0, data: addr});
    for (int i = 0; i <= ready_delay; i++) begin
      dcache_req_ready = (i == ready_delay);
      @(negedge clk);
      if (stall) stall_cycles++;
      check_output({tag, "_req_valid"}, {31'd0, dcache_req_valid}, 32'd1);
      check_output({tag, "_addr"}, dcache_addr, exp_addr);
      check_output({tag, "_we"}, {28'd0, dcache_we}, {28'd0, exp_we});
      check_output({tag, "_din"}, dcache_din, exp_din);
      next_cycle();
    end
    idle_inputs();
    check_output({tag, "_stall_cycles"}, stall_cycles, ready_delay);
  endtask

  // Spurious responses are offered before/at the accept cycle and must be ignored
  task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [4:0] rd_i, input int ready_delay, input int wait_cycles,
                          input logic [31:0] dout_val, input logic [31:0] exp_data);
    int stall_cycles = 0;
    apply_stimulus(f3, 4'b0000, 1'b1, WB_MEM, 1'b1, rd_i, addr, 32'd0, 32'd0);
    exp_q.push_back('{rd: rd_i, we: (rd_i != 5'd0), data: exp_data});
    for (int i = 0; i <= ready_delay; i++) begin
      dcache_req_ready  = (i == ready_delay);
      dcache_resp_valid = (i == ready_delay);
      dcache_dout       = 32'hDEAD_BEEF;
      @(negedge clk);
      if (stall) stall_cycles++;
      check_output({tag, "_req_valid"}, {31'd0, dcache_req_valid}, 32'd1);
      check_output({tag, "_addr"}, dcache_addr, {addr[31:2], 2'b00});
      check_output({tag, "_re"}, {31'd0, dcache_re}, 32'd1);
      next_cycle();
    end
    dcache_req_ready = 0;
    for (int i = 0; i <= wait_cycles; i++) begin
      dcache_resp_valid = (i == wait_cycles);
      dcache_dout       = (i == wait_cycles) ? dout_val : 32'hDEAD_BEEF;
      @(negedge clk);
      if (stall) stall_cycles++;
      check_output({tag, "_req_idle"}, {31'd0, dcache_req_valid}, 32'd0);
      next_cycle();
    end
    idle_inputs();
    check_output({tag, "_stall_cycles"}, stall_cycles, ready_delay + 1 + wait_cycles);
  endtask

  // Monitor: pop one expectation per writeback pulse
  always @(negedge clk) begin
    if (reset_n && wb_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_wb actual rd=%0d data=0x%0h, expected no writeback", wb_rd, wb_data);
      end else begin
        mon_exp = exp_q.pop_front();
        check_output("wb_rd", {27'd0, wb_rd}, {27'd0, mon_exp.rd});
        check_output("wb_we", {31'd0, wb_we}, {31'd0, mon_exp.we});
        check_output("wb_data", wb_data, mon_exp.data);
      end
    end
  end

  initial begin
    reset_n = 0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    check_output("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    check_output("rst_wb_we", {31'd0, wb_we}, 32'd0);
    check_output("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
    check_output("rst_wb_data", wb_data, 32'd0);
    check_output("rst_stall", {31'd0, stall}, 32'd0);
    check_output("rst_req_valid", {31'd0, dcache_req_valid}, 32'd0);
    next_cycle();
    reset_n = 1;
    next_cycle();

    run_alu("add", WB_ALU, 5'd5, 32'h0000_1234, 32'd0, 1'b1, 32'h0000_1234);
    run_store("sb", F3_LB, 4'b0001, 32'h0000_0103, 32'h0000_00AB, 3,
              32'h0000_0100, 4'b1000, 32'hAB00_0000);
    run_load("lh", F3_LH, 32'h0000_0102, 5'd7, 0, 2, 32'h8001_7FFF, 32'hFFFF_8001);
    run_load("lhu", F3_LHU, 32'h0000_0102, 5'd8, 1, 2, 32'h8001_7FFF, 32'h0000_8001);
    run_alu("jal", WB_PC4, 5'd0, 32'h0000_0999, 32'h0000_0044, 1'b0, 32'h0000_0044);
    run_alu("zero_sel", WB_ZERO, 5'd4, 32'h0000_5555, 32'h0000_0044, 1'b1, 32'h0000_0000);
    run_load("lb", F3_LB, 32'h0000_0101, 5'd10, 0, 0, 32'h0000_80FF, 32'hFFFF_FF80);
    run_load("lbu", F3_LBU, 32'h0000_0103, 5'd11, 2, 1, 32'hFE00_0000, 32'h0000_00FE);
    run_load("lw", F3_LW, 32'h0000_0204, 5'd12, 0, 1, 32'hCAFE_F00D, 32'hCAFE_F00D);
    run_store("sw", F3_LW, 4'b1111, 32'h0000_0204, 32'h1234_5678, 0,
              32'h0000_0204, 4'b1111, 32'h1234_5678);
`ifndef MW_MISALIGN_TRAP_EN
    run_load("lw_mask", F3_LW, 32'h0000_0102, 5'd13, 0, 0, 32'hCAFE_F00D, 32'hCAFE_F00D);
    run_store("sh_mask", F3_LH, 4'b0011, 32'h0000_0103, 32'h0000_5678, 1,
              32'h0000_0100, 4'b1100, 32'h5678_0000);
`endif

    // Reset during WAIT_RESP, then a late response that must be ignored
    apply_stimulus(F3_LW, 4'b0000, 1'b1, WB_MEM, 1'b1, 5'd9, 32'h0000_0200, 32'd0, 32'd0);
    dcache_req_ready = 1;
    @(negedge clk);
    check_output("rst_mid_accept_stall", {31'd0, stall}, 32'd1);
    next_cycle();
    reset_n = 0;
    idle_inputs();
    @(negedge clk);
    check_output("rst_mid_stall", {31'd0, stall}, 32'd0);
    check_output("rst_mid_req_valid", {31'd0, dcache_req_valid}, 32'd0);
    next_cycle();
    reset_n = 1;
    dcache_resp_valid = 1;
    dcache_dout = 32'h1234_5678;
    @(negedge clk);
    check_output("late_resp_stall", {31'd0, stall}, 32'd0);
    check_output("late_resp_wb_valid", {31'd0, wb_valid}, 32'd0);
    next_cycle();
    dcache_resp_valid = 0;
    @(negedge clk);
    check_output("late_resp_wb_valid2", {31'd0, wb_valid}, 32'd0);
    check_output("late_resp_req_valid", {31'd0, dcache_req_valid}, 32'd0);
    next_cycle();

    run_alu("post_rst_add", WB_ALU, 5'd6, 32'h0000_00C0, 32'd0, 1'b1, 32'h0000_00C0);

`ifdef MW_MISALIGN_TRAP_EN
    apply_stimulus(F3_LW, 4'b0000, 1'b1, WB_MEM, 1'b1, 5'd3, 32'h0000_0101, 32'd0, 32'd0);
    dcache_req_ready = 1;
    exp_q.push_back('{rd: 5'd3, we: 1'b0, data: 32'd0});
    @(negedge clk);
    check_output("mis_req_valid", {31'd0, dcache_req_valid}, 32'd0);
    check_output("mis_stall", {31'd0, stall}, 32'd0);
    check_output("mis_err_early", {31'd0, misalign_err}, 32'd0);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check_output("mis_err", {31'd0, misalign_err}, 32'd1);
    next_cycle();
    @(negedge clk);
    check_output("mis_err_pulse", {31'd0, misalign_err}, 32'd0);
    next_cycle();
`endif

    next_cycle();
    next_cycle();
    check_output("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
